// File: rtl/byte_parity_pkg.sv
// byte_parity_pkg: shared constants, types and reference parity
// for the registered per-byte parity generator.
package byte_parity_pkg;

    localparam int DATA_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = DATA_W / BYTE_W;

    typedef logic [NUM_BYTES-1:0] parity_t;

    function automatic parity_t golden_parity(
        input logic [DATA_W-1:0] d,
        input bit                odd
    );
        parity_t p;
        p = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            p[i] = (^d[i*BYTE_W +: BYTE_W]) ^ odd;
        end
        return p;
    endfunction

endpackage

// File: rtl/byte_parity_lane.sv
// parity_lane: combinational parity of one byte lane,
// inverted when odd parity is selected.
module parity_lane
    import byte_parity_pkg::*;
#(
    parameter int BYTE_W = byte_parity_pkg::BYTE_W,
    parameter bit ODD    = 1'b0
) (
    input  logic [BYTE_W-1:0] lane_in,
    output logic              par
);

    assign par = (^lane_in) ^ ODD;

endmodule

// File: rtl/byte_parity.sv
// byte_parity: one register stage carrying a data word and its
// per-byte parity side-band, always updated together.
module byte_parity
    import byte_parity_pkg::*;
#(
    parameter int DATA_W = byte_parity_pkg::DATA_W,
    parameter int BYTE_W = byte_parity_pkg::BYTE_W,
    parameter bit ODD    = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [DATA_W/BYTE_W-1:0] parity
);

    localparam int NB = DATA_W / BYTE_W;

    // Parity of an all-zero word, so reset leaves a consistent pair.
    localparam logic [NB-1:0] RST_PAR = ODD ? {NB{1'b1}} : {NB{1'b0}};

    if (DATA_W % BYTE_W != 0) begin : g_width_check
        $error("byte_parity: DATA_W must be a multiple of BYTE_W");
    end

    logic [NB-1:0]     lane_par;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;
    logic [NB-1:0]     parity_d;
    logic [NB-1:0]     parity_q;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        parity_lane #(
            .BYTE_W (BYTE_W),
            .ODD    (ODD)
        ) u_lane (
            .lane_in (din[i*BYTE_W +: BYTE_W]),
            .par     (lane_par[i])
        );
    end

    // The reset mux sits in front of the flops so din never leaks through.
    always_comb begin
        dout_d   = din;
        parity_d = lane_par;
        if (!rst_n) begin
            dout_d   = '0;
            parity_d = RST_PAR;
        end
    end

    always_ff @(posedge clk) begin
        dout_q   <= dout_d;
        parity_q <= parity_d;
    end

    assign dout   = dout_q;
    assign parity = parity_q;

endmodule

// File: tb/tb_byte_parity.sv
// tb_byte_parity: scoreboard bench driving even and odd instances
// in parallel against a bit-counting reference model.
module tb_byte_parity;
    import byte_parity_pkg::*;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  p_even;
        logic [3:0]  p_odd;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [31:0] dout_e;
    logic [3:0]  par_e;
    logic [31:0] dout_o;
    logic [3:0]  par_o;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    byte_parity #(.DATA_W(32), .BYTE_W(8), .ODD(1'b0)) u_even (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .dout   (dout_e),
        .parity (par_e)
    );

    byte_parity #(.DATA_W(32), .BYTE_W(8), .ODD(1'b1)) u_odd (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .dout   (dout_o),
        .parity (par_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count the ones in each byte; odd count means even-parity bit set.
    function automatic logic [3:0] model_par(input logic [31:0] d,
                                             input bit odd);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = d[8*i +: 8];
            p[i] = (($countones(b) % 2) == 1) ? ~odd : odd;
        end
        return p;
    endfunction

    task automatic step(input logic r, input logic [31:0] d,
                        input bit use_x, input string tag);
        exp_t e;
        int unsigned dly;
        rst_n = r;
        din   = use_x ? 'x : d;
        if (!r) begin
            e.d      = 32'h0;
            e.p_even = 4'b0000;
            e.p_odd  = 4'b1111;
        end else begin
            e.d      = d;
            e.p_even = model_par(d, 1'b0);
            e.p_odd  = model_par(d, 1'b1);
        end
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        dly = $urandom_range(2, 8);
        #(dly);
    endtask

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act,
                          input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Monitor: the DUT presents a new pair after every edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check32({e.tag, "_dout_even"}, dout_e, e.d);
                check4 ({e.tag, "_par_even"},  par_e,  e.p_even);
                check32({e.tag, "_dout_odd"},  dout_o, e.d);
                check4 ({e.tag, "_par_odd"},   par_o,  e.p_odd);
            end
        end
    end

    initial begin
        logic [31:0] dir [4];
        int waited;
        checks = 0;
        errors = 0;
        dir[0] = 32'h0000_0001;
        dir[1] = 32'hFFFF_FFFF;
        dir[2] = 32'h0103_0700;
        dir[3] = 32'h8000_0080;

        for (int i = 0; i < 5; i++) begin
            step(1'b0, $urandom, (i % 2) == 0, "reset");
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, dir[i], 1'b0, "directed");
        end
        for (int k = 0; k < 32; k++) begin
            step(1'b1, 32'h1 << k, 1'b0, "walk");
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, $urandom, 1'b0, "stream");
        end
        step(1'b0, $urandom, 1'b0, "midreset");
        step(1'b1, 32'hA5C3_0F01, 1'b0, "postreset");
        for (int i = 0; i < 45; i++) begin
            step(1'b1, $urandom, 1'b0, "random");
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0",
                     exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
